imem_loader: RTL

Boot-time program loader that is the driving end of the CPU's instruction stream: it accepts a byte stream over a valid/ready interface, assembles little-endian 32-bit instruction words, writes them sequentially into instruction memory from byte address 0, and holds the RISCV core in reset until the load completes. It sits between an external byte source (UART receiver or bench driver) and the IMEM write port / core reset input, so programs can be loaded at run time instead of through a preloaded memory image.

---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and IMEM write-port bundle for the boot-time program loader.
// The slave modport is the loader, and the master modport is the byte source/memory side.
interface imem_loader_if #(
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = 32
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic [INST_WIDTH-1:0] imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: receives a 16-bit word count, then little-endian instruction words,
// writes them into IMEM from address 0, and holds the core in reset until the load has finished.
module imem_loader #(
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int IMEM_DEPTH = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    imem_loader_if.slave  bus,
    input  logic          reload,
    output logic          cpu_reset_n,
    output logic          done,
    output logic          overflow
);
    typedef enum logic [1:0] {
        CNT_LO = 2'd0,
        CNT_HI = 2'd1,
        DATA   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(IMEM_DEPTH);

    state_t                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           word_idx_q, word_idx_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           word_q, word_d;
    logic                  we_q, we_d;
    logic [PC_WIDTH-1:0]   addr_q, addr_d;
    logic [INST_WIDTH-1:0] wdata_q, wdata_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic                  in_range;

    assign bus.in_ready   = (state_q != DONE);
    assign accept         = bus.in_valid && (state_q != DONE);
    assign in_range       = {1'b0, word_idx_q} < DEPTH_W;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_reset_n    = done_q;
    assign done           = done_q;
    assign overflow       = ovf_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ovf_d      = ovf_q;
        // Core release trails DONE entry by one edge and drops on the reload edge itself
        done_d     = (state_q == DONE) && !reload;

        case (state_q)
            CNT_LO: begin
                if (accept) begin
                    count_d[7:0] = bus.in_data;
                    state_d      = CNT_HI;
                end
            end
            CNT_HI: begin
                if (accept) begin
                    count_d[15:8] = bus.in_data;
                    state_d = ({bus.in_data, count_q[7:0]} == 16'd0) ? DONE : DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: word_d[7:0]   = bus.in_data;
                        2'd1: word_d[15:8]  = bus.in_data;
                        2'd2: word_d[23:16] = bus.in_data;
                        default: begin
                            // Words past the end of IMEM are still consumed so the stream stays in sync
                            if (in_range) begin
                                we_d    = 1'b1;
                                addr_d  = PC_WIDTH'({word_idx_q, 2'b00});
                                wdata_d = INST_WIDTH'({bus.in_data, word_q});
                            end else begin
                                ovf_d = 1'b1;
                            end
                            word_idx_d = word_idx_q + 16'd1;
                            if (word_idx_q == count_q - 16'd1) begin
                                state_d = DONE;
                            end
                        end
                    endcase
                end
            end
            DONE: begin
                if (reload) begin
                    state_d    = CNT_LO;
                    count_d    = '0;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    addr_d     = '0;
                    ovf_d      = 1'b0;
                end
            end
            default: state_d = CNT_LO;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= CNT_LO;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end
endmodule
